stream_kernel_wrapper: RTL

- Generic, parametrised driver for a 1:1 streaming kernel (one output line per input line).
- Flow: reads IN_LINES lines from an input buffer by offset, registers them into the kernel, and writes kernel results in order to an output buffer.
- Improvements over the single-use fixed-width wrapper:
  - Configurable width and buffer IDs.
  - Credit-based flow control with an output skid FIFO, so write-side backpressure never drops data.
  - Restartable after completion.
  - Handles zero-length jobs.
- Sits between the buffer-access layer and any kernel, such as the gaussian filter.

---
 rtl/stream_kernel_wrapper.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/stream_kernel_wrapper.sv
// Streaming 1:1 kernel driver: credit-limited buffer reads, registered kernel input, skid FIFO on writes.
// Optional performance counters are built when STREAM_WRAPPER_PERF_EN is defined.
module stream_kernel_wrapper #(
  parameter int unsigned DATA_W     = 512,
  parameter int unsigned OFFSET_W   = 18,
  parameter int unsigned BUF_IN_ID  = 1,
  parameter int unsigned BUF_OUT_ID = 0,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                finish,
  input  logic [OFFSET_W-1:0] in_size,
  input  logic [OFFSET_W-1:0] out_size,
  output logic                rd_req_valid,
  output logic [7:0]          rd_req_buf,
  output logic [OFFSET_W-1:0] rd_req_offset,
  input  logic                rd_full,
  input  logic [DATA_W-1:0]   rd_rsp_data,
  input  logic                rd_rsp_valid,
  output logic [DATA_W-1:0]   k_data_in,
  output logic                k_valid_in,
  input  logic [DATA_W-1:0]   k_data_out,
  input  logic                k_valid_out,
  output logic                wr_req_valid,
  output logic [7:0]          wr_req_buf,
  output logic [DATA_W-1:0]   wr_req_data,
  input  logic                wr_full
`ifdef STREAM_WRAPPER_PERF_EN
  ,
  output logic [31:0]         perf_cycles,
  output logic [31:0]         perf_rd_stall,
  output logic [31:0]         perf_wr_stall
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          state, state_next;
  logic [OFFSET_W-1:0] in_size_q, out_size_q;
  logic [OFFSET_W-1:0] rd_issued, wr_count, wr_count_next;
  logic [CW-1:0]       inflight, fifo_count;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];

  logic start_ok, rd_want, credit_ok, rd_take, push, pop, k_dec;

  // All request outputs decode flops only; no input-to-output paths.
  assign start_ok      = start && ((state == S_IDLE) || (state == S_DONE));
  assign credit_ok     = (SW'(inflight) + SW'(fifo_count)) < SW'(FIFO_DEPTH);
  assign rd_want       = (state == S_RUN) && (rd_issued != in_size_q);
  assign rd_req_valid  = rd_want && credit_ok;
  assign rd_req_offset = rd_issued;
  assign rd_req_buf    = rd_req_valid ? 8'(BUF_IN_ID) : 8'd0;
  assign rd_take       = rd_req_valid && !rd_full;
  assign push          = k_valid_out;
  assign k_dec         = k_valid_out && (inflight != '0);
  assign wr_req_valid  = (fifo_count != '0);
  assign wr_req_buf    = wr_req_valid ? 8'(BUF_OUT_ID) : 8'd0;
  assign wr_req_data   = wr_req_valid ? mem[rd_ptr] : '0;
  assign pop           = wr_req_valid && !wr_full;
  assign wr_count_next = wr_count + OFFSET_W'(pop);

  // Next-state: transitions look at this cycle's take/pop so finish rises one cycle after the last write.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = ((in_size == '0) && (out_size == '0)) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if ((rd_issued == in_size_q) ||
            (rd_take && ((rd_issued + OFFSET_W'(1)) == in_size_q))) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (wr_count_next == out_size_q) begin
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      finish     <= 1'b0;
      in_size_q  <= '0;
      out_size_q <= '0;
      rd_issued  <= '0;
      wr_count   <= '0;
    end else begin
      state  <= state_next;
      finish <= (state_next == S_DONE);
      if (start_ok) begin
        in_size_q  <= in_size;
        out_size_q <= out_size;
        rd_issued  <= '0;
        wr_count   <= '0;
      end else begin
        if (rd_take) rd_issued <= rd_issued + OFFSET_W'(1);
        wr_count <= wr_count_next;
      end
    end
  end

  // Kernel input stage; a reset cycle drops any response arriving with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      k_valid_in <= 1'b0;
      k_data_in  <= '0;
    end else begin
      k_valid_in <= rd_rsp_valid;
      k_data_in  <= rd_rsp_data;
    end
  end

  // Credit and skid FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      case ({rd_take, k_dec})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (pop && !push) fifo_count <= fifo_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= k_data_out;
  end

`ifdef STREAM_WRAPPER_PERF_EN
  logic busy;
  assign busy = (state == S_RUN) || (state == S_DRAIN);

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      perf_cycles   <= '0;
      perf_rd_stall <= '0;
      perf_wr_stall <= '0;
    end else if (busy) begin
      perf_cycles <= perf_cycles + 32'd1;
      if (rd_want && !rd_take)    perf_rd_stall <= perf_rd_stall + 32'd1;
      if (wr_req_valid && wr_full) perf_wr_stall <= perf_wr_stall + 32'd1;
    end
  end
`endif

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (fifo_count == CW'(FIFO_DEPTH))));

  a_no_surplus_output: assert property (@(posedge clk) disable iff (reset)
    !(k_valid_out && (state == S_DONE)));

endmodule
